// File: rtl/multi_fade_pwm.sv
// Multi-channel LED fader: one prescaled phase accumulator feeds CHANNELS PWM
// outputs at equal phase offsets, each shaped by a selectable waveform.
module multi_fade_pwm #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PHASE_BITS = 11,
  parameter int SPEED_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [SPEED_BITS-1:0] i_speed,
  input  logic [1:0]            i_mode,
  output logic [CHANNELS-1:0]   o_led,
  output logic                  o_tick,
  output logic [PHASE_BITS-1:0] o_phase
);

  localparam int OFFSET = (2 ** PHASE_BITS) / CHANNELS;
  localparam int SHIFT  = PHASE_BITS - 1 - PWM_BITS;

  logic [SPEED_BITS-1:0] presc_q, presc_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  tick_q, tick_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  pwm_wrap;

  // The >= compare lets a lowered i_speed fire on the very next cycle.
  always_comb begin
    presc_d   = presc_q;
    phase_d   = phase_q;
    tick_d    = 1'b0;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (i_enable && (i_speed != '0)) begin
      if (presc_q >= i_speed - SPEED_BITS'(1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
        phase_d = phase_q + PHASE_BITS'(1);
      end else begin
        presc_d = presc_q + SPEED_BITS'(1);
      end
    end
  end

  assign pwm_wrap = (pwm_cnt_q == '1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q   <= '0;
      phase_q   <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Only the top PWM_BITS+1 bits of the channel phase shape the waveform.
      logic [PWM_BITS:0]   ph_top;
      logic [PWM_BITS-1:0] tri_val;
      logic [PWM_BITS-1:0] duty_calc;
      logic [PWM_BITS-1:0] duty_q, duty_d;
      logic                led_q, led_d;

      assign ph_top = (PWM_BITS+1)'((phase_q + PHASE_BITS'(gi * OFFSET)) >> SHIFT);

      always_comb begin
        tri_val   = ph_top[PWM_BITS] ? ~ph_top[PWM_BITS-1:0] : ph_top[PWM_BITS-1:0];
        duty_calc = '0;
        case (i_mode)
          2'd0:    duty_calc = tri_val;
          2'd1:    duty_calc = ph_top[PWM_BITS:1];
          2'd2:    duty_calc = ph_top[PWM_BITS] ? '0 : '1;
          default: duty_calc = PWM_BITS'(({{PWM_BITS{1'b0}}, tri_val} *
                                           {{PWM_BITS{1'b0}}, tri_val}) >> PWM_BITS);
        endcase
        // Duty only changes at the period boundary so a running period is never cut.
        duty_d = pwm_wrap ? duty_calc : duty_q;
        led_d  = i_enable && (pwm_cnt_q < duty_q);
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          duty_q <= '0;
          led_q  <= 1'b0;
        end else begin
          duty_q <= duty_d;
          led_q  <= led_d;
        end
      end

      assign o_led[gi] = led_q;
    end
  endgenerate

  assign o_tick  = tick_q;
  assign o_phase = phase_q;

endmodule

// File: doc/multi_fade_pwm.md
Name: multi_fade_pwm

Overview:
- Multi-channel smooth-fade LED driver.
- One shared phase accumulator, advanced by a programmable prescaler, drives CHANNELS PWM outputs.
- Each channel sits at an equal phase offset and uses a selectable waveform: triangle, sawtooth, square or gamma-corrected triangle.
- It replaces the single-channel fixed-triangle fader and feeds the board LED pins directly.

Parameters:
CHANNELS, 3, number of LED outputs (1..16)
PWM_BITS, 8, PWM counter and duty resolution
PHASE_BITS, 11, phase accumulator width; requirement: PHASE_BITS-1 >= PWM_BITS
SPEED_BITS, 16, width of i_speed

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_enable  in  1  run enable; low freezes phase and blanks LEDs
i_speed  in  SPEED_BITS  clock cycles per phase step; 0 = halted
i_mode  in  2  waveform: 0 triangle, 1 sawtooth, 2 square, 3 gamma triangle
o_led  out  CHANNELS  PWM outputs, bit k = channel k
o_tick  out  1  one-cycle pulse on each phase step
o_phase  out  PHASE_BITS  master phase value

Behaviour:
- One clock domain: i_clk. Reset is synchronous and active-high on i_rst, sampled at the posedge of i_clk.
- Reset values: prescaler 0, o_phase 0, pwm_cnt 0, all duty_q 0, o_led 0, o_tick 0. Reset mid-operation takes effect on the next edge and overrides all other inputs.

Prescaler:
- Active when i_enable=1 and i_speed!=0.
- When prescaler >= i_speed-1: prescaler <= 0, o_tick <= 1, phase <= phase+1. Otherwise prescaler increments and o_tick <= 0.
- Result: exactly one tick every i_speed cycles.
- Lowering i_speed below the current count produces a tick on the next cycle. It must never hang.
- i_speed=0 or i_enable=0: prescaler and phase hold; o_tick <= 0.

Phase:
- o_phase wraps modulo 2^PHASE_BITS; 2^PHASE_BITS-1 -> 0 with no extra event.
- OFFSET = floor(2^PHASE_BITS / CHANNELS).
- Channel k phase: ph_k = (phase + k*OFFSET) mod 2^PHASE_BITS.

Waveforms (combinational from ph_k and i_mode; T = PHASE_BITS-1):
- Triangle value: t = ph_k[MSB] ? ~ph_k[T-1:0] : ph_k[T-1:0]. tri = t[T-1 -: PWM_BITS].
- mode 0: duty = tri.
- mode 1: duty = ph_k[PHASE_BITS-1 -: PWM_BITS].
- mode 2: duty = ph_k[MSB] ? 0 : all-ones.
- mode 3: duty = (tri*tri) >> PWM_BITS, using a 2*PWM_BITS product.

PWM:
- pwm_cnt is a free-running PWM_BITS counter that runs even when i_enable=0.
- duty_q[k] loads the computed duty only on the cycle where pwm_cnt == all-ones. The new value therefore applies from pwm_cnt=0. Mode or phase changes never alter a PWM period in progress.
- o_led[k] <= i_enable & (pwm_cnt < duty_q[k]), registered, one cycle of latency from pwm_cnt.
- duty 0 gives constant 0. duty all-ones gives 2^PWM_BITS-1 high cycles per 2^PWM_BITS.
- i_enable falling: o_led is 0 on the next edge. i_enable rising: phase resumes from the held value; LEDs follow the current duty_q.

Simultaneous events:
- A tick coinciding with the pwm_cnt wrap: duty_q loads from the pre-increment phase value.

Test Plan:
(defaults CHANNELS=3, PWM_BITS=8, PHASE_BITS=11, so OFFSET=682)
1. i_rst high 4 cycles with all inputs active -> o_led=0, o_tick=0, o_phase=0. Release with i_speed=0, i_enable=1 for 1000 cycles -> no o_tick, o_phase stays 0.
2. i_speed=4, i_enable=1 -> o_tick on every 4th cycle. o_phase=N after N ticks. After 2048 ticks o_phase=0. Switching i_speed 200 -> 3 mid-count gives a tick within 1 cycle, then period 3.
3. i_speed=0, phase 0, mode 0, 512 cycles settled -> per 256-cycle period: o_led[0] high 0 cycles, o_led[1] high 170 cycles (ph 682), o_led[2] high 170 cycles (ph 1364). Force phase to 1023 -> ch0 high 255 cycles.
4. Same as scenario 3 with mode 3 -> ch1 and ch2 high 112 cycles per period; ch0 high 0. Mode 2 -> ch0 255, ch1 255, ch2 0.
5. Change i_mode 0 -> 2 at pwm_cnt=100 -> current period's high count unchanged (170 for ch1). The new duty appears from the next pwm_cnt=0.
6. Drop i_enable at arbitrary cycle -> o_led=0 the next cycle and o_phase frozen for 300 cycles. Re-enable -> phase continues. Assert i_rst mid-period -> all outputs 0 the next cycle.
